bvh_traversal_unit_p: RTL

//  Parametrised stack-based BVH traversal engine for one ray; successor of the fixed 2-child BVH unit.

---
 rtl/bvh_traversal_unit_p_if.sv | 28 ++
 rtl/bvh_traversal_unit_p.sv | 107 ++++++++++
 2 files changed

// File: rtl/bvh_traversal_unit_p_if.sv
// bvh_traversal_unit_p_if: node-fetch and leaf-range stream handshakes of the BVH traversal unit.
// master = traversal unit, slave = node memory / primitive tester side.
interface bvh_traversal_unit_p_if #(
    parameter int NODE_INDEX_WIDTH = 8,
    parameter int PRIM_INDEX_WIDTH = 12,
    parameter int PRIM_AMOUNT_WIDTH = 4
);
    logic                           node_req;
    logic [NODE_INDEX_WIDTH-1:0]    node_index;
    logic                           node_valid;
    logic                           node_hit;
    logic [2*NODE_INDEX_WIDTH-1:0]  child_index;
    logic [1:0]                     child_hit;
    logic [2*PRIM_INDEX_WIDTH-1:0]  leaf_start;
    logic [2*PRIM_AMOUNT_WIDTH-1:0] leaf_num;
    logic                           prim_valid;
    logic                           prim_ready;
    logic [PRIM_INDEX_WIDTH-1:0]    prim_start;
    logic [PRIM_AMOUNT_WIDTH-1:0]   prim_num;
    modport master (
        output node_req, node_index, prim_valid, prim_start, prim_num,
        input  node_valid, node_hit, child_index, child_hit, leaf_start, leaf_num, prim_ready
    );
    modport slave (
        input  node_req, node_index, prim_valid, prim_start, prim_num,
        output node_valid, node_hit, child_index, child_hit, leaf_start, leaf_num, prim_ready
    );
endinterface

// File: rtl/bvh_traversal_unit_p.sv
// bvh_traversal_unit_p: stack-based BVH traversal for one ray with near-first child order,
// leaf range streaming under back-pressure, sticky stack overflow and abort.
module bvh_traversal_unit_p #(
    parameter int NODE_INDEX_WIDTH = 8,
    parameter int STACK_DEPTH = 16,
    parameter int PRIM_INDEX_WIDTH = 12,
    parameter int PRIM_AMOUNT_WIDTH = 4,
    parameter logic [NODE_INDEX_WIDTH-1:0] ROOT_INDEX = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic near_first,
    bvh_traversal_unit_p_if.master bus,
    output logic busy,
    output logic done,
    output logic overflow
);
    localparam int NIW = NODE_INDEX_WIDTH;
    localparam int PIW = PRIM_INDEX_WIDTH;
    localparam int PAW = PRIM_AMOUNT_WIDTH;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);
    typedef enum logic [2:0] {IDLE, FETCH, EMIT, POP, DONE} state_t;
    state_t state, state_nx;
    logic [NIW-1:0] cur, f_idx, s_idx;
    logic [NIW-1:0] stack [STACK_DEPTH];
    logic [SPW-1:0] sp, sp_a;
    logic [PIW-1:0] q0_start, q1_start, f_start, s_start;
    logic [PAW-1:0] q0_num, q1_num, f_num, s_num;
    logic q_two, f_leaf, s_leaf, take, hit, push_s, push_f, drop, fire, go;
    // F is the child visited/emitted first, S the other one
    always_comb begin
        f_idx = near_first ? bus.child_index[2*NIW-1:NIW] : bus.child_index[NIW-1:0];
        s_idx = near_first ? bus.child_index[NIW-1:0] : bus.child_index[2*NIW-1:NIW];
        f_start = near_first ? bus.leaf_start[2*PIW-1:PIW] : bus.leaf_start[PIW-1:0];
        s_start = near_first ? bus.leaf_start[PIW-1:0] : bus.leaf_start[2*PIW-1:PIW];
        f_num = near_first ? bus.leaf_num[2*PAW-1:PAW] : bus.leaf_num[PAW-1:0];
        s_num = near_first ? bus.leaf_num[PAW-1:0] : bus.leaf_num[2*PAW-1:PAW];
        f_leaf = f_idx[NIW-1] && bus.child_hit[near_first] && f_num != '0;
        s_leaf = s_idx[NIW-1] && bus.child_hit[!near_first] && s_num != '0;
        take = state == FETCH && bus.node_valid;
        hit = take && bus.node_hit;
        push_s = hit && !s_idx[NIW-1] && sp != FULL;
        sp_a = sp + SPW'(push_s);
        push_f = hit && !f_idx[NIW-1] && sp_a != FULL;
        drop = hit && ((!s_idx[NIW-1] && !push_s) || (!f_idx[NIW-1] && !push_f));
        fire = state == EMIT && bus.prim_ready;
        go = start && (state == IDLE || state == DONE);
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? FETCH : state;
            FETCH: state_nx = !take ? FETCH : (bus.node_hit && (f_leaf || s_leaf)) ? EMIT : POP;
            EMIT: state_nx = (fire && !q_two) ? POP : EMIT;
            POP: state_nx = sp == '0 ? DONE : FETCH;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
        bus.node_req = state == FETCH;
        bus.node_index = cur;
        bus.prim_valid = state == EMIT;
        bus.prim_start = q0_start;
        bus.prim_num = q0_num;
        busy = state != IDLE && state != DONE;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sp <= '0;
            cur <= '0;
            overflow <= 1'b0;
            q0_start <= '0;
            q0_num <= '0;
            q1_start <= '0;
            q1_num <= '0;
            q_two <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) sp <= '0;
            else if (go) begin
                cur <= ROOT_INDEX;
                sp <= '0;
                overflow <= 1'b0;
            end else if (take) begin
                sp <= sp_a + SPW'(push_f);
                overflow <= overflow | drop;
                if (push_s) stack[AW'(sp)] <= s_idx;
                if (push_f) stack[AW'(sp_a)] <= f_idx;
                q0_start <= f_leaf ? f_start : s_start;
                q0_num <= f_leaf ? f_num : s_num;
                q1_start <= s_start;
                q1_num <= s_num;
                q_two <= f_leaf && s_leaf;
            end else if (fire) begin
                q0_start <= q1_start;
                q0_num <= q1_num;
                q_two <= 1'b0;
            end else if (state == POP && sp != '0) begin
                sp <= sp - 1'b1;
                cur <= stack[AW'(sp - 1'b1)];
            end
        end
    end
endmodule
